fifo_lane: RTL and testbench
============================

# fifo_lane

Per-lane receive FIFO placed directly downstream of the 1-to-2 demultiplexer; one instance consumes `dataout0`/`valid_0`, a second consumes `dataout1`/`valid_1`. Buffers 4-bit words written at the lane rate and releases them on a registered pop interface for the next stage. Flags full, empty, and programmable almost-full and almost-empty for back-pressure, plus optional sticky overflow and underflow error flags.

## Interface
Parameters:
- `DATA_W`, 4, word width; matches the demux data path.
- `DEPTH`, 8, number of entries; must be a power of two, at least 4.
- `ADDR_W`, 3, log2(`DEPTH`).
- `AF_THRESH`, 6, `almost_full` asserts when count ≥ this value.
- `AE_THRESH`, 2, `almost_empty` asserts when count ≤ this value.

Ports:
- `clk`  in  1  the only clock; all state is updated on the rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  push request; driven by the demux `valid_0` or `valid_1`.
- `data_in`  in  `DATA_W`  push data; driven by the demux `dataout0` or `dataout1`.
- `pop`  in  1  read request from the downstream stage.
- `data_out`  out  `DATA_W`  registered read data.
- `valid_out`  out  1  `data_out` holds a popped word this cycle.
- `full`, `empty`  out  1 each  occupancy flags.
- `almost_full`, `almost_empty`  out  1 each  threshold flags.
- `count`  out  `ADDR_W+1`  current occupancy, from 0 to `DEPTH`.
- `err_overflow`, `err_underflow`  out  1 each  sticky error flags (see Configuration).

## Operation
- **Reset (async assert, sync release).** Reset clears the read pointer, write pointer and count to 0, and sets every output to:

  | Output | Reset value |
  |---|---|
  | `data_out` | 0 |
  | `valid_out` | 0 |
  | `full` | 0 |
  | `empty` | 1 |
  | `almost_full` | 0 |
  | `almost_empty` | 1 |
  | `err_*` | 0 |

  Memory contents are not reset. A reset in mid-operation discards all stored words immediately.
- **Push accepted** when `valid_in`=1 and either (not full) or (`pop`=1 in the same cycle). The word is written at `wr_ptr`, and `wr_ptr` increments modulo `DEPTH`.
- **Pop accepted** when `pop`=1 and not empty. On the next edge, `data_out` takes the word at `rd_ptr`, `valid_out` goes to 1, and `rd_ptr` increments modulo `DEPTH`.
- **Cycles with no accepted pop:** `valid_out`=0 and `data_out`=0. The output is zeroed, consistent with the demux idle behaviour.
- **Count update:** +1 for a push alone, −1 for a pop alone, unchanged for push and pop together. Pointers wrap naturally at `ADDR_W` bits.
- **Full with simultaneous push and pop:** both are accepted and the count stays at `DEPTH`.
- **Empty with simultaneous push and pop:** the push is accepted and the pop is rejected (no bypass path). This counts as an underflow.
- **Push while full without pop:** the word is dropped and the pointers do not change. This counts as an overflow.
- **Pop while empty:** ignored. This counts as an underflow.
- **Flags** are decoded from the registered count and are valid in the same cycle as `count`:
  - `full` = (count == `DEPTH`)
  - `empty` = (count == 0)
  - `almost_full` = (count ≥ `AF_THRESH`)
  - `almost_empty` = (count ≤ `AE_THRESH`)

## Timing
- Write-to-read latency is 2 edges. Edge N writes the word; `pop` can be sampled with the word visible at edge N+1; the word appears on `data_out` after edge N+1.
- Pop-to-data latency is 1 cycle.
- The flags and `count` change on the same edge as the push or pop that caused the change.
- Full throughput: one push and one pop per cycle can be sustained indefinitely at any occupancy from 1 to `DEPTH`.

## Configuration
- Macro: `FIFO_LANE_ERR_EN`.
- **Defined:**
  - `err_overflow` sets on a dropped push.
  - `err_underflow` sets on a rejected pop.
  - Both flags stay at 1 until `reset_L` asserts.
- **Undefined:**
  - Both error ports are tied to 0.
  - No error registers are synthesised.
  - Dropping and rejection behaviour is unchanged.

## Structure
- The shared package holds:
  - the default `DATA_W`, `DEPTH` and `ADDR_W` constants, shared with the demux so lane widths agree;
  - a `fifo_lane_flags_t` struct with fields `full`, `empty`, `almost_full` and `almost_empty`.
- Sub-module `fifo_lane_mem`: a `DEPTH`×`DATA_W` register file with one synchronous write port and one asynchronous read port, and no reset. The control logic (pointers, count, flags, errors, output register) stays in `fifo_lane`.

## Test plan
- **Reset mid-stream:** push 0x3, 0x5, 0x9; assert `reset_L`=0 asynchronously between edges.
  - Required: all outputs return to their reset values immediately; `count`=0.
  - Required: after release, pop gives `valid_out`=0.
- **Ordering:** push 0x1 through 0x8 on consecutive cycles, then pop 8 times.
  - Required: `data_out` = 1, 2, …, 8 with `valid_out`=1.
  - Required: `full`=1 after the 8th push; `empty`=1 after the 8th pop.
- **Thresholds:** fill to 6.
  - Required: `almost_full` rises on the 6th push, and `almost_empty` falls on the 3rd push.
  - Drain to 2. Required: `almost_empty` re-asserts and `almost_full` clears at count 5.
- **Overflow at full:** at count 8, push 0xA with `pop`=0.
  - Required: the word is dropped; `count` stays 8; `err_overflow`=1 with the macro, 0 without.
  - Then push 0xB and pop together. Required: pop returns the oldest word and `count` stays 8.
- **Underflow at empty:** pop alone.
  - Required: `valid_out`=0 and `err_underflow`=1 (with the macro).
  - Push 0xC and pop together on empty. Required: `count`=1 and `valid_out`=0; the next pop returns 0xC.
- **Demux-driven stream:** connect behind the demux and drive 0x1, 0x2, 0x3, 0x4.
  - Required: lane-0 and lane-1 instances each hold 2 words, matching the demux alternation order, and read back intact.

Source files
------------

// File: rtl/fifo_lane_pkg.sv
// fifo_lane_pkg: shared lane constants and flag bundle for the per-lane
// receive FIFO. The default widths are shared with the 1-to-2 demux so
// that both sides of the lane interface agree.
package fifo_lane_pkg;

  localparam int FIFO_LANE_DATA_W = 4;
  localparam int FIFO_LANE_DEPTH  = 8;
  localparam int FIFO_LANE_ADDR_W = 3;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_lane_flags_t;

endpackage

// File: rtl/fifo_lane_mem.sv
// fifo_lane_mem: DEPTH x DATA_W register file with one synchronous write
// port and one asynchronous read port. Storage is deliberately not reset.
module fifo_lane_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_lane.sv
// fifo_lane: per-lane receive FIFO behind the 1-to-2 demux. Registered pop
// output, occupancy count and threshold flags decoded from the registered
// count. Optional sticky overflow/underflow flags are built only when the
// macro FIFO_LANE_ERR_EN is defined; otherwise both error ports read 0.
module fifo_lane
  import fifo_lane_pkg::*;
#(
  parameter int DATA_W    = FIFO_LANE_DATA_W,
  parameter int DEPTH     = FIFO_LANE_DEPTH,
  parameter int ADDR_W    = FIFO_LANE_ADDR_W,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic [DATA_W-1:0] rdata;
  logic              push_ok, pop_ok;
  fifo_lane_flags_t  flags;

  // Decode occupancy flags from the registered count.
  always_comb begin
    flags              = '0;
    flags.full         = (count_q == DEPTH_C);
    flags.empty        = (count_q == '0);
    flags.almost_full  = (count_q >= AF_C);
    flags.almost_empty = (count_q <= AE_C);
  end

  // Accept logic: a pop frees a slot when full, but there is no bypass when empty.
  always_comb begin
    push_ok     = valid_in && (!flags.full || pop);
    pop_ok      = pop && !flags.empty;
    wr_ptr_d    = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    valid_out_d = pop_ok;
    data_out_d  = pop_ok ? rdata : '0;
  end

  // Control and output registers; reset discards all stored words.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

`ifdef FIFO_LANE_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_unf_q, err_unf_d;

  // Sticky error flags: dropped push sets overflow, rejected pop sets underflow.
  always_comb begin
    err_ovf_d = err_ovf_q || (valid_in && flags.full && !pop);
    err_unf_d = err_unf_q || (pop && flags.empty);
  end

  // Error flags hold until reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

  fifo_lane_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign count        = count_q;
  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

endmodule

// File: tb/tb_fifo_lane.sv
// tb_fifo_lane: directed self-checking bench for fifo_lane, including a
// pair of lane instances fed by a small alternating demux model.
module tb_fifo_lane;

`ifdef FIFO_LANE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       vi = 1'b0;
  logic [3:0] di = '0;
  logic       pp = 1'b0;
  logic [3:0] dout;
  logic       vout, full, empty, af, ae, eovf, eunf;
  logic [3:0] cnt;

  // demux-fed lane pair
  logic       v0 = 1'b0, v1 = 1'b0, pl = 1'b0;
  logic [3:0] dmx = '0;
  logic [3:0] d0, d1, c0, c1;
  logic       vo0, vo1, f0, f1, e0, e1, af0, af1, ae0, ae1;
  logic       eo0, eo1, eu0, eu1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_lane u_dut (
    .clk(clk), .reset_L(reset_L), .valid_in(vi), .data_in(di), .pop(pp),
    .data_out(dout), .valid_out(vout), .full(full), .empty(empty),
    .almost_full(af), .almost_empty(ae), .count(cnt),
    .err_overflow(eovf), .err_underflow(eunf)
  );

  fifo_lane u_lane0 (
    .clk(clk), .reset_L(reset_L), .valid_in(v0), .data_in(dmx), .pop(pl),
    .data_out(d0), .valid_out(vo0), .full(f0), .empty(e0),
    .almost_full(af0), .almost_empty(ae0), .count(c0),
    .err_overflow(eo0), .err_underflow(eu0)
  );

  fifo_lane u_lane1 (
    .clk(clk), .reset_L(reset_L), .valid_in(v1), .data_in(dmx), .pop(pl),
    .data_out(d1), .valid_out(vo1), .full(f1), .empty(e1),
    .almost_full(af1), .almost_empty(ae1), .count(c1),
    .err_overflow(eo1), .err_underflow(eu1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 reset_L = 1'b0;
    #2 reset_L = 1'b1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_count", 32'(cnt), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(ae), 1);
    chk("rst_af", 32'(af), 0);
    chk("rst_vout", 32'(vout), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_eovf", 32'(eovf), 0);
    chk("rst_eunf", 32'(eunf), 0);
    reset_L = 1'b1;
    step();

    // reset mid-stream
    vi = 1'b1; di = 4'h3; step();
    di = 4'h5; step();
    di = 4'h9; step();
    vi = 1'b0;
    chk("mid_count3", 32'(cnt), 3);
    chk("mid_ae_low", 32'(ae), 0);
    #1 reset_L = 1'b0;
    #1;
    chk("mid_rst_count", 32'(cnt), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_ae", 32'(ae), 1);
    #1 reset_L = 1'b1;
    pp = 1'b1; step(); pp = 1'b0;
    chk("mid_pop_vout", 32'(vout), 0);
    chk("mid_pop_dout", 32'(dout), 0);
    chk("mid_pop_eunf", 32'(eunf), 32'(ERR_EN));
    do_reset();
    step();

    // fill with 1..8, checking thresholds on each push
    vi = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      di = 4'(k);
      step();
      chk($sformatf("fill_count%0d", k), 32'(cnt), 32'(k));
      chk($sformatf("fill_ae%0d", k), 32'(ae), (k <= 2) ? 1 : 0);
      chk($sformatf("fill_af%0d", k), 32'(af), (k >= 6) ? 1 : 0);
      chk($sformatf("fill_vout%0d", k), 32'(vout), 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_empty", 32'(empty), 0);

    // overflow: push 0xA while full, no pop
    di = 4'hA; step();
    chk("ovf_count", 32'(cnt), 8);
    chk("ovf_eovf", 32'(eovf), 32'(ERR_EN));
    chk("ovf_eunf", 32'(eunf), 0);

    // push 0xB and pop together at full
    di = 4'hB; pp = 1'b1; step();
    vi = 1'b0;
    chk("full_pp_vout", 32'(vout), 1);
    chk("full_pp_dout", 32'(dout), 1);
    chk("full_pp_count", 32'(cnt), 8);

    // drain: expect 2..8 then 0xB; 0xA must be absent
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("drain_vout%0d", k), 32'(vout), 1);
      chk($sformatf("drain_dout%0d", k), 32'(dout), (k == 8) ? 32'hB : 32'(k + 1));
      chk($sformatf("drain_count%0d", k), 32'(cnt), 32'(8 - k));
      chk($sformatf("drain_af%0d", k), 32'(af), ((8 - k) >= 6) ? 1 : 0);
      chk($sformatf("drain_ae%0d", k), 32'(ae), ((8 - k) <= 2) ? 1 : 0);
    end
    chk("drain_empty", 32'(empty), 1);
    pp = 1'b0; step();
    chk("idle_vout", 32'(vout), 0);
    chk("idle_dout", 32'(dout), 0);

    // underflow at empty
    do_reset();
    step();
    pp = 1'b1; step();
    chk("unf_vout", 32'(vout), 0);
    chk("unf_eunf", 32'(eunf), 32'(ERR_EN));
    chk("unf_count", 32'(cnt), 0);
    vi = 1'b1; di = 4'hC; step();
    vi = 1'b0;
    chk("unf_pp_count", 32'(cnt), 1);
    chk("unf_pp_vout", 32'(vout), 0);
    step();
    pp = 1'b0;
    chk("unf_next_vout", 32'(vout), 1);
    chk("unf_next_dout", 32'(dout), 32'hC);
    chk("unf_next_count", 32'(cnt), 0);

    // demux-driven stream: alternate lanes starting with lane 0
    for (int k = 1; k <= 4; k++) begin
      dmx = 4'(k);
      v0  = (k % 2) == 1;
      v1  = (k % 2) == 0;
      step();
    end
    v0 = 1'b0; v1 = 1'b0; dmx = '0;
    chk("dmx_c0", 32'(c0), 2);
    chk("dmx_c1", 32'(c1), 2);
    pl = 1'b1; step();
    chk("dmx_l0_w1", 32'({vo0, d0}), 32'h11);
    chk("dmx_l1_w1", 32'({vo1, d1}), 32'h12);
    step();
    pl = 1'b0;
    chk("dmx_l0_w2", 32'({vo0, d0}), 32'h13);
    chk("dmx_l1_w2", 32'({vo1, d1}), 32'h14);
    chk("dmx_e0", 32'(e0), 1);
    chk("dmx_e1", 32'(e1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
